// File: rtl/e_reg_pkg.sv
// ---------------------------------------------------------------------------
// e_reg_pkg
//   Shared widths and Y86 encodings used by the Decode->Execute pipeline
//   register and its load/use detector.
//   Contents:
//     WORD_W, REG_W, STAT_W, CNT_W   default widths
//     INOP, IRRMOVL, IMRMOVL, IOPL, IPOPL   instruction codes
//     FNONE                          "no function" code
//     RNONE                          "no register" ID
//     SBUB, SAOK                     status codes
// ---------------------------------------------------------------------------
package e_reg_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 8;
  localparam int STAT_W = 3;
  localparam int CNT_W  = 16;

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IPOPL   = 4'hB;

  localparam logic [3:0] FNONE = 4'h0;

  localparam logic [REG_W-1:0] RNONE = 8'h0F;

  localparam logic [STAT_W-1:0] SBUB = 3'd0;
  localparam logic [STAT_W-1:0] SAOK = 3'd1;

endpackage

// File: rtl/e_reg_loaduse_det.sv
// ---------------------------------------------------------------------------
// e_reg_loaduse_det
//   Purely combinational load/use hazard detector. Flags when the instruction
//   sitting in E is a memory load (mrmovl/popl) whose memory destination is
//   read as a source by the instruction now in D.
//   Ports:
//     e_icode   in  4      icode held in E
//     e_dstm    in  REG_W  memory destination held in E
//     d_srca    in  REG_W  source A of instruction in D
//     d_srcb    in  REG_W  source B of instruction in D
//     loaduse   out 1      hazard flag
// ---------------------------------------------------------------------------
module e_reg_loaduse_det
  import e_reg_pkg::*;
#(
  parameter int REG_W = e_reg_pkg::REG_W
) (
  input  logic [3:0]       e_icode,
  input  logic [REG_W-1:0] e_dstm,
  input  logic [REG_W-1:0] d_srca,
  input  logic [REG_W-1:0] d_srcb,
  output logic             loaduse
);

  logic is_load;
  logic dst_valid;

  // An RNONE destination can never create a hazard; equality with a valid
  // destination already implies the matching source is not RNONE.
  always_comb begin
    is_load   = (e_icode == IMRMOVL) || (e_icode == IPOPL);
    dst_valid = (e_dstm != REG_W'(RNONE));
    loaduse   = is_load && dst_valid && ((e_dstm == d_srca) || (e_dstm == d_srcb));
  end

endmodule

// File: rtl/e_reg.sv
// ---------------------------------------------------------------------------
// e_reg
//   Decode->Execute pipeline register of the 5-stage Y86 pipe. Captures the
//   decoded fields and forwarded operands each cycle, holds on stall, loads a
//   nop on bubble (bubble beats stall), counts injected bubbles with
//   saturation, and flags load/use hazards against the instruction in D.
//   Ports:
//     clk, rst (async, active-low)
//     E_stall_i, E_bubble_i          pipeline control
//     d_*_i                          decode-stage fields (10 of them)
//     E_*_o                          registered copies of the d_*_i fields
//     loaduse_o                      comb load/use hazard flag
//     bubble_cnt_o                   saturating count of injected bubbles
// ---------------------------------------------------------------------------
module e_reg
  import e_reg_pkg::*;
#(
  parameter int WORD_W = e_reg_pkg::WORD_W,
  parameter int REG_W  = e_reg_pkg::REG_W,
  parameter int STAT_W = e_reg_pkg::STAT_W,
  parameter int CNT_W  = e_reg_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              E_stall_i,
  input  logic              E_bubble_i,
  input  logic [STAT_W-1:0] d_stat_i,
  input  logic [3:0]        d_icode_i,
  input  logic [3:0]        d_ifun_i,
  input  logic [WORD_W-1:0] d_valC_i,
  input  logic [WORD_W-1:0] d_valA_i,
  input  logic [WORD_W-1:0] d_valB_i,
  input  logic [REG_W-1:0]  d_dstE_i,
  input  logic [REG_W-1:0]  d_dstM_i,
  input  logic [REG_W-1:0]  d_srcA_i,
  input  logic [REG_W-1:0]  d_srcB_i,
  output logic [STAT_W-1:0] E_stat_o,
  output logic [3:0]        E_icode_o,
  output logic [3:0]        E_ifun_o,
  output logic [WORD_W-1:0] E_valC_o,
  output logic [WORD_W-1:0] E_valA_o,
  output logic [WORD_W-1:0] E_valB_o,
  output logic [REG_W-1:0]  E_dstE_o,
  output logic [REG_W-1:0]  E_dstM_o,
  output logic [REG_W-1:0]  E_srcA_o,
  output logic [REG_W-1:0]  E_srcB_o,
  output logic              loaduse_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  // Register bank: reset and bubble load the same nop image, so a bubble is
  // indistinguishable downstream from a freshly reset stage. All ten fields
  // share one priority chain so they always update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      E_stat_o  <= STAT_W'(SBUB);
      E_icode_o <= INOP;
      E_ifun_o  <= FNONE;
      E_valC_o  <= '0;
      E_valA_o  <= '0;
      E_valB_o  <= '0;
      E_dstE_o  <= REG_W'(RNONE);
      E_dstM_o  <= REG_W'(RNONE);
      E_srcA_o  <= REG_W'(RNONE);
      E_srcB_o  <= REG_W'(RNONE);
    end else if (E_bubble_i) begin
      E_stat_o  <= STAT_W'(SBUB);
      E_icode_o <= INOP;
      E_ifun_o  <= FNONE;
      E_valC_o  <= '0;
      E_valA_o  <= '0;
      E_valB_o  <= '0;
      E_dstE_o  <= REG_W'(RNONE);
      E_dstM_o  <= REG_W'(RNONE);
      E_srcA_o  <= REG_W'(RNONE);
      E_srcB_o  <= REG_W'(RNONE);
    end else if (!E_stall_i) begin
      E_stat_o  <= d_stat_i;
      E_icode_o <= d_icode_i;
      E_ifun_o  <= d_ifun_i;
      E_valC_o  <= d_valC_i;
      E_valA_o  <= d_valA_i;
      E_valB_o  <= d_valB_i;
      E_dstE_o  <= d_dstE_i;
      E_dstM_o  <= d_dstM_i;
      E_srcA_o  <= d_srcA_i;
      E_srcB_o  <= d_srcB_i;
    end
  end

  // Bubble counter sticks at all-ones instead of wrapping, so a long-running
  // stat read never looks like a small number.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt_o <= '0;
    end else if (E_bubble_i && (bubble_cnt_o != '1)) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

  e_reg_loaduse_det #(
    .REG_W (REG_W)
  ) u_loaduse_det (
    .e_icode (E_icode_o),
    .e_dstm  (E_dstM_o),
    .d_srca  (d_srcA_i),
    .d_srcb  (d_srcB_i),
    .loaduse (loaduse_o)
  );

endmodule
